// File: rtl/fp_issue.sv
// fp_issue: single-outstanding issue stage between the core and an FP
// execute unit. It accepts one operation, resolves the dynamic rounding mode,
// issues it with a one-cycle strobe, waits for the result (bounded by
// TIMEOUT), returns a tagged response and accrues sticky exception flags.
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   req_*                       core request (valid/ready, operands, op, fmt, rm, tag)
//   frm                         dynamic rounding mode (used when req_rm == 3'b111)
//   exe_enable, exe_*           issue strobe and held operands to the execute unit
//   exe_result/flags/ready      execute-unit response
//   rsp_*                       response to the core (valid/ready handshake)
//   fflags, fflags_clr          sticky accrued flags and their clear

package fp_issue_pkg;
    localparam int FP_OP_W = 8;
    typedef logic [FP_OP_W-1:0] fp_operation_type;   // one-hot
    localparam fp_operation_type FP_OP_FADD  = 8'h01;
    localparam fp_operation_type FP_OP_FSUB  = 8'h02;
    localparam fp_operation_type FP_OP_FMUL  = 8'h04;
    localparam fp_operation_type FP_OP_FDIV  = 8'h08;
    localparam fp_operation_type FP_OP_FSQRT = 8'h10;
    localparam fp_operation_type FP_OP_FSGNJ = 8'h20;
    localparam fp_operation_type FP_OP_FMNMX = 8'h40;
    localparam fp_operation_type FP_OP_FCVT  = 8'h80;
endpackage

module fp_issue
    import fp_issue_pkg::*;
#(
    parameter int TIMEOUT = 63     // WAIT cycles before abandoning (1..64)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_data1,
    input  logic [31:0]      req_data2,
    input  logic [31:0]      req_data3,
    input  fp_operation_type req_op,
    input  logic [1:0]       req_fmt,
    input  logic [2:0]       req_rm,
    input  logic [4:0]       req_tag,
    input  logic [2:0]       frm,
    output logic             exe_enable,
    output logic [31:0]      exe_data1,
    output logic [31:0]      exe_data2,
    output logic [31:0]      exe_data3,
    output fp_operation_type exe_op,
    output logic [1:0]       exe_fmt,
    output logic [2:0]       exe_rm,
    input  logic [31:0]      exe_result,
    input  logic [4:0]       exe_flags,
    input  logic             exe_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic [4:0]       rsp_flags,
    output logic [4:0]       rsp_tag,
    output logic             rsp_illegal,
    output logic             rsp_timeout,
    output logic [4:0]       fflags,
    input  logic             fflags_clr
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    typedef struct packed {
        logic [31:0]      d1, d2, d3;
        fp_operation_type op;
        logic [1:0]       fmt;
        logic [2:0]       rm;
        logic [4:0]       tag;
    } req_t;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  flags;
        logic        illegal;
        logic        timeout;
    } rsp_t;

    state_t      state, state_nxt;
    req_t        hold_q;
    rsp_t        rsp_q;
    logic [5:0]  wait_cnt;
    logic [4:0]  fflags_q;
    logic [2:0]  rm_res;
    logic        rm_bad, accept, wait_lim, rsp_hs, exe_cap;

    assign rm_res   = (req_rm == 3'b111) ? frm : req_rm;
    assign rm_bad   = (rm_res == 3'd5) || (rm_res == 3'd6);
    assign accept   = (state == S_IDLE) && req_valid;
    // Counter holds (cycles spent in WAIT - 1), so the limit cycle is the TIMEOUT-th.
    assign wait_lim = (wait_cnt == 6'(TIMEOUT - 1));
    assign rsp_hs   = (state == S_RESP) && rsp_ready;
    assign exe_cap  = ((state == S_ISSUE) || (state == S_WAIT)) && exe_ready;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (req_valid) state_nxt = rm_bad ? S_RESP : S_ISSUE;
            S_ISSUE: state_nxt = exe_ready ? S_RESP : S_WAIT;
            S_WAIT:  if (exe_ready || wait_lim) state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // outputs
    always_comb begin
        req_ready   = 1'b0;
        exe_enable  = 1'b0;
        exe_data1   = '0;
        exe_data2   = '0;
        exe_data3   = '0;
        exe_op      = '0;
        exe_fmt     = '0;
        exe_rm      = '0;
        rsp_valid   = 1'b0;
        rsp_result  = '0;
        rsp_flags   = '0;
        rsp_tag     = '0;
        rsp_illegal = 1'b0;
        rsp_timeout = 1'b0;
        case (state)
            S_IDLE: req_ready = 1'b1;
            S_ISSUE, S_WAIT: begin
                exe_enable = (state == S_ISSUE);
                exe_data1  = hold_q.d1;
                exe_data2  = hold_q.d2;
                exe_data3  = hold_q.d3;
                exe_op     = hold_q.op;
                exe_fmt    = hold_q.fmt;
                exe_rm     = hold_q.rm;
            end
            S_RESP: begin
                rsp_valid   = 1'b1;
                rsp_result  = rsp_q.result;
                rsp_flags   = rsp_q.flags;
                rsp_tag     = hold_q.tag;
                rsp_illegal = rsp_q.illegal;
                rsp_timeout = rsp_q.timeout;
            end
            default: ;
        endcase
    end

    // datapath: held request, response capture, wait counter, sticky flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q   <= '0;
            rsp_q    <= '0;
            wait_cnt <= '0;
            fflags_q <= '0;
        end else begin
            if (accept) begin
                hold_q.d1  <= req_data1;
                hold_q.d2  <= req_data2;
                hold_q.d3  <= req_data3;
                hold_q.op  <= req_op;
                hold_q.fmt <= req_fmt;
                hold_q.rm  <= rm_res;
                hold_q.tag <= req_tag;
                rsp_q      <= '0;
                rsp_q.illegal <= rm_bad;
            end

            if (state == S_ISSUE)     wait_cnt <= '0;
            else if (state == S_WAIT) wait_cnt <= wait_cnt + 6'd1;

            // a ready on the limit cycle wins over the timeout
            if (exe_cap) begin
                rsp_q.result  <= exe_result;
                rsp_q.flags   <= exe_flags;
                rsp_q.illegal <= 1'b0;
                rsp_q.timeout <= 1'b0;
            end else if ((state == S_WAIT) && wait_lim) begin
                rsp_q.result  <= '0;
                rsp_q.flags   <= '0;
                rsp_q.timeout <= 1'b1;
            end

            if (rsp_hs) begin
                rsp_q    <= '0;
                fflags_q <= (fflags_clr ? 5'd0 : fflags_q) | rsp_q.flags;
            end else if (fflags_clr) begin
                fflags_q <= '0;
            end
        end
    end

    assign fflags = fflags_q;

endmodule

// File: tb/tb_fp_issue.sv
// Randomized bench for fp_issue. The execute unit and core are modelled per
// transaction: the bench decides when the result arrives (ISSUE, k-th WAIT
// cycle or never) and derives every expected output from that choice.
module tb_fp_issue;
    import fp_issue_pkg::*;

    localparam int TIMEOUT = 63;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid, req_ready;
    logic [31:0]      req_data1, req_data2, req_data3;
    fp_operation_type req_op;
    logic [1:0]       req_fmt;
    logic [2:0]       req_rm, frm;
    logic [4:0]       req_tag;
    logic             exe_enable;
    logic [31:0]      exe_data1, exe_data2, exe_data3;
    fp_operation_type exe_op;
    logic [1:0]       exe_fmt;
    logic [2:0]       exe_rm;
    logic [31:0]      exe_result;
    logic [4:0]       exe_flags;
    logic             exe_ready;
    logic             rsp_valid, rsp_ready;
    logic [31:0]      rsp_result;
    logic [4:0]       rsp_flags, rsp_tag;
    logic             rsp_illegal, rsp_timeout;
    logic [4:0]       fflags;
    logic             fflags_clr;

    fp_issue #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data1(req_data1), .req_data2(req_data2), .req_data3(req_data3),
        .req_op(req_op), .req_fmt(req_fmt), .req_rm(req_rm), .req_tag(req_tag),
        .frm(frm),
        .exe_enable(exe_enable),
        .exe_data1(exe_data1), .exe_data2(exe_data2), .exe_data3(exe_data3),
        .exe_op(exe_op), .exe_fmt(exe_fmt), .exe_rm(exe_rm),
        .exe_result(exe_result), .exe_flags(exe_flags), .exe_ready(exe_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_tag(rsp_tag),
        .rsp_illegal(rsp_illegal), .rsp_timeout(rsp_timeout),
        .fflags(fflags), .fflags_clr(fflags_clr)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [4:0] m_fflags = '0;   // reference accrued flags

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic noise_exe();
        exe_ready  = 1'($urandom_range(0, 1));
        exe_result = $urandom;
        exe_flags  = 5'($urandom);
    endtask

    // lat: 0 = ready in ISSUE, 1..TIMEOUT = ready in that WAIT cycle, >TIMEOUT = never
    task automatic run_txn(input fp_operation_type op, input logic [2:0] rm, input logic [2:0] f,
                           input int lat, input int hold, input logic clr, input logic [4:0] ef);
        logic [31:0] d1, d2, d3, er, exp_res;
        logic [1:0]  fmt;
        logic [4:0]  tag, exp_flg;
        logic [2:0]  rm_exp;
        logic        illegal, timed_out;
        int          nwait;
        d1 = $urandom; d2 = $urandom; d3 = $urandom; er = $urandom;
        fmt = 2'($urandom); tag = 5'($urandom);
        rm_exp    = (rm == 3'd7) ? f : rm;
        illegal   = (rm_exp == 3'd5) || (rm_exp == 3'd6);
        timed_out = !illegal && (lat > TIMEOUT);
        exp_res   = (illegal || timed_out) ? 32'd0 : er;
        exp_flg   = (illegal || timed_out) ? 5'd0 : ef;

        @(negedge clk);
        chk("idle_req_ready", req_ready, 1);
        req_valid = 1'b1; req_data1 = d1; req_data2 = d2; req_data3 = d3;
        req_op = op; req_fmt = fmt; req_rm = rm; req_tag = tag; frm = f;
        noise_exe();
        @(negedge clk);
        req_valid = 1'b0;
        req_data1 = $urandom; req_data2 = $urandom; req_data3 = $urandom;
        req_tag = 5'($urandom); frm = 3'($urandom);
        chk("busy_req_ready", req_ready, 0);
        if (!illegal) begin
            chk("issue_en", exe_enable, 1);
            chk("issue_rsp_valid", rsp_valid, 0);
            chk("issue_d1", exe_data1, d1);
            chk("issue_d2", exe_data2, d2);
            chk("issue_d3", exe_data3, d3);
            chk("issue_op", exe_op, op);
            chk("issue_fmt", exe_fmt, fmt);
            chk("issue_rm", exe_rm, rm_exp);
            exe_ready  = (lat == 0);
            exe_result = (lat == 0) ? er : $urandom;
            exe_flags  = (lat == 0) ? ef : 5'($urandom);
            nwait = (lat == 0) ? 0 : (timed_out ? TIMEOUT : lat);
            for (int k = 1; k <= nwait; k++) begin
                @(negedge clk);
                chk("wait_en", exe_enable, 0);
                chk("wait_rsp_valid", rsp_valid, 0);
                chk("wait_d1", exe_data1, d1);
                chk("wait_d3", exe_data3, d3);
                chk("wait_op", exe_op, op);
                chk("wait_rm", exe_rm, rm_exp);
                exe_ready  = (k == lat);
                exe_result = (k == lat) ? er : $urandom;
                exe_flags  = (k == lat) ? ef : 5'($urandom);
            end
            @(negedge clk);
        end
        for (int h = 0; h <= hold; h++) begin
            chk("resp_valid", rsp_valid, 1);
            chk("resp_result", rsp_result, exp_res);
            chk("resp_flags", rsp_flags, exp_flg);
            chk("resp_tag", rsp_tag, tag);
            chk("resp_illegal", rsp_illegal, illegal);
            chk("resp_timeout", rsp_timeout, timed_out);
            chk("resp_exe_en", exe_enable, 0);
            chk("resp_exe_d1", exe_data1, 0);
            chk("resp_exe_op", exe_op, 0);
            chk("resp_req_ready", req_ready, 0);
            noise_exe();
            rsp_ready  = (h == hold);
            fflags_clr = (h == hold) ? clr : 1'b0;
            @(negedge clk);
        end
        rsp_ready = 1'b0; fflags_clr = 1'b0;
        m_fflags = (clr ? 5'd0 : m_fflags) | exp_flg;
        chk("hs_rsp_valid", rsp_valid, 0);
        chk("hs_req_ready", req_ready, 1);
        chk("hs_fflags", fflags, m_fflags);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            fflags_clr = ($urandom_range(0, 3) == 0);
            noise_exe();
            rsp_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (fflags_clr) m_fflags = '0;
            fflags_clr = 1'b0;
            chk("idle_rsp_valid", rsp_valid, 0);
            chk("idle_fflags", fflags, m_fflags);
        end
        rsp_ready = 1'b0;
    endtask

    task automatic reset_mid_wait();
        @(negedge clk);
        req_valid = 1'b1; req_op = FP_OP_FDIV; req_rm = 3'd0; req_tag = 5'd9;
        req_data1 = $urandom; exe_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_rst_exe_d1_live", (exe_data1 == req_data1), 1);
        rst_n = 1'b0;
        #1;
        m_fflags = '0;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_exe_d1", exe_data1, 0);
        chk("rst_fflags", fflags, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exe_ready = 1'b1; exe_result = $urandom; exe_flags = 5'h1f;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_rsp_valid", rsp_valid, 0);
            chk("post_rst_req_ready", req_ready, 1);
            chk("post_rst_exe_en", exe_enable, 0);
            chk("post_rst_rsp_result", rsp_result, 0);
            chk("post_rst_fflags", fflags, 0);
        end
        exe_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 0; req_data1 = 0; req_data2 = 0; req_data3 = 0;
        req_op = '0; req_fmt = 0; req_rm = 0; req_tag = 0; frm = 0;
        exe_result = 0; exe_flags = 0; exe_ready = 0; rsp_ready = 0; fflags_clr = 0;
        repeat (2) @(negedge clk);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_exe_en", exe_enable, 0);
        chk("reset_exe_d1", exe_data1, 0);
        chk("reset_rsp_tag", rsp_tag, 0);
        chk("reset_fflags", fflags, 0);
        rst_n = 1'b1;

        run_txn(FP_OP_FSGNJ, 3'd0, 3'd0, 0, 0, 1'b0, 5'd0);             // single-cycle
        run_txn(FP_OP_FDIV,  3'd0, 3'd0, 12, 0, 1'b0, 5'b00001);        // 12 WAIT cycles
        run_txn(FP_OP_FADD,  3'd7, 3'd3, 1, 0, 1'b0, 5'd0);             // frm resolve
        run_txn(FP_OP_FMUL,  3'd7, 3'd5, 0, 0, 1'b0, 5'b11111);         // illegal via frm
        run_txn(FP_OP_FSUB,  3'd6, 3'd0, 0, 1, 1'b0, 5'b11111);         // illegal direct
        run_txn(FP_OP_FSQRT, 3'd0, 3'd0, TIMEOUT + 1, 0, 1'b0, 5'b11111); // timeout
        run_txn(FP_OP_FCVT,  3'd2, 3'd0, TIMEOUT, 0, 1'b0, 5'b00100);   // ready on limit
        run_txn(FP_OP_FADD,  3'd1, 3'd0, 2, 4, 1'b1, 5'b10000);         // stall + clr
        reset_mid_wait();

        for (int t = 0; t < 40; t++) begin
            int lat;
            case ($urandom_range(0, 5))
                0:       lat = 0;
                1:       lat = TIMEOUT;
                2:       lat = TIMEOUT + 1;
                default: lat = $urandom_range(1, 20);
            endcase
            run_txn(fp_operation_type'(8'd1 << $urandom_range(0, 7)),
                    3'($urandom), 3'($urandom), lat, $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), 5'($urandom));
            idle_cycles($urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fp_issue.md
FP_ISSUE -- requirements
Module: fp_issue

Interface
REQ-001 Parameter TIMEOUT, default 63: maximum number of WAIT cycles before a request is abandoned.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  core presents an FP operation.
REQ-005 req_ready  output  1  block accepts the operation.
REQ-006 req_data1/req_data2/req_data3  input  32 each  raw operands.
REQ-007 req_op  input  fp_operation_type  one-hot operation.
REQ-008 req_fmt  input  2  format; req_rm  input  3  instruction rounding mode; req_tag  input  5  destination tag.
REQ-009 frm  input  3  dynamic rounding mode from the CSR.
REQ-010 exe_enable  output  1  issue strobe to the execute unit.
REQ-011 exe_data1/2/3  output  32; exe_op  output  fp_operation_type; exe_fmt  output  2; exe_rm  output  3  held operands.
REQ-012 exe_result  input  32; exe_flags  input  5; exe_ready  input  1  execute-unit response.
REQ-013 rsp_valid  output  1; rsp_ready  input  1  response handshake.
REQ-014 rsp_result  output  32; rsp_flags  output  5; rsp_tag  output  5; rsp_illegal  output  1; rsp_timeout  output  1.
REQ-015 fflags  output  5  sticky accrued exception flags; fflags_clr  input  1  clears fflags.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP; req_ready = 1 only in IDLE.
REQ-017 In IDLE, when req_valid=1, the block SHALL register operands, op, fmt and tag, and resolve rm to frm when req_rm=3'b111.
- If the resolved rm is 5 or 6: go to RESP with rsp_illegal=1, result 0, flags 0, no issue.
- Otherwise: go to ISSUE.
REQ-018 exe_data*, exe_op, exe_fmt and exe_rm SHALL be driven from registers and held stable through ISSUE and WAIT; they SHALL be 0 (op all-zero) in IDLE and RESP.
REQ-019 exe_enable SHALL be 1 in ISSUE only, exactly one cycle per accepted request.
REQ-020 In ISSUE, the block SHALL capture exe_result/exe_flags and go to RESP when exe_ready=1; otherwise it SHALL go to WAIT.
- Single-cycle ops: acceptance to rsp_valid = 2 cycles.
REQ-021 In WAIT, the block SHALL capture exe_result/exe_flags on the first cycle with exe_ready=1 and go to RESP; exe_ready in IDLE or RESP SHALL be ignored.
REQ-022 A 6-bit wait counter SHALL clear on entering WAIT and increment each WAIT cycle.
- On reaching TIMEOUT with exe_ready=0: go to RESP with rsp_timeout=1, result 0, flags 0.
- exe_ready=1 in the same cycle as the limit takes priority over timeout.
REQ-023 In RESP, rsp_valid=1 and response fields SHALL be held stable until rsp_ready=1; then go to IDLE.
REQ-024 On each response handshake: fflags <= fflags | rsp_flags (timeout and illegal contribute 0).
- fflags_clr alone: fflags <= 0.
- fflags_clr coincident with a handshake: fflags <= rsp_flags.
REQ-025 rsp_tag SHALL equal the req_tag of the accepted request; at most one request SHALL be outstanding.

Reset
REQ-026 When reset is 0, state SHALL be IDLE; all held registers, counter, rsp_* and fflags SHALL be 0; req_ready SHALL be 1 once reset is released.
REQ-027 Reset asserted in ISSUE, WAIT or RESP SHALL abandon the operation with no response and no fflags update; a later exe_ready SHALL be ignored.

Verification
REQ-028 fsgnj, rm=0, exe_ready=1 in ISSUE, rsp_ready=1 -> rsp_valid 2 cycles after acceptance, rsp_result=exe_result, rsp_tag matched, req_ready back after 3 cycles.
REQ-029 fdiv, exe_ready after 12 WAIT cycles with flags=5'b00001 -> operands stable for 13 cycles, exe_enable high 1 cycle only, rsp_flags=1, fflags=1.
REQ-030 req_rm=7, frm=3 -> exe_rm=3; req_rm=7, frm=5 -> rsp_illegal=1, exe_enable never asserted.
REQ-031 exe_ready held 0, TIMEOUT=63 -> rsp_timeout=1 after 63 WAIT cycles, result 0, fflags unchanged.
REQ-032 rsp_ready held low 4 cycles, then fflags_clr coincident with handshake of flags 5'b10000 -> response stable throughout, final fflags=5'b10000.
REQ-033 reset pulsed low mid-WAIT, then exe_ready=1 -> no rsp_valid, all outputs 0, fflags 0.
